spi_reg_if: RTL and testbench

// - SPI slave to register-bus bridge. The external MCU drives SPI; the block issues

---
 rtl/spi_reg_if_pkg.sv | 25 ++
 rtl/spi_sync2.sv | 21 ++
 rtl/spi_reg_if.sv | 143 ++++++++++++++
 tb/tb_spi_reg_if.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_if_pkg.sv
// Shared frame geometry and state encoding for the SPI-to-register-bus bridge.
package spi_reg_if_pkg;

    localparam int HDR_BITS  = 16;
    localparam int TURN_BITS = 8;
    localparam int DATA_BITS = 32;
    localparam int W_BIT     = 15;
    localparam int CNT_W     = 6;

    // Counter value seen on the rising edge that completes each phase.
    localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(HDR_BITS - 1);
    localparam logic [CNT_W-1:0] WDATA_LAST = CNT_W'(HDR_BITS + DATA_BITS - 1);
    localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(HDR_BITS + TURN_BITS - 1);
    localparam logic [CNT_W-1:0] RDATA_LAST = CNT_W'(HDR_BITS + TURN_BITS + DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_WDATA,
        ST_TURN,
        ST_RDATA,
        ST_DONE
    } state_t;

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchroniser bringing one asynchronous SPI pin into the clk domain.
module spi_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_reg_if.sv
// SPI mode-0 slave that turns each chip-select frame into one register-bus read or write.
module spi_reg_if
    import spi_reg_if_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              spi_ncs,
    input  logic              spi_di,
    output logic              spi_do,
    output logic              r_valid,
    output logic              r_wen,
    output logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_wdata,
    input  logic [DATA_W-1:0] r_rdata
);

    logic sck_s, ncs_s, di_s;
    logic sck_d, ncs_d;
    logic sck_rise, sck_fall, ncs_fall;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [DATA_W-1:0] sr_in;
    logic [DATA_W-1:0] sr_out;
    logic [ADDR_W-1:0] hdr_addr;

    spi_sync2 u_sync_sck (.clk(clk), .reset(reset), .d(spi_clk), .q(sck_s));
    spi_sync2 u_sync_ncs (.clk(clk), .reset(reset), .d(spi_ncs), .q(ncs_s));
    spi_sync2 u_sync_di  (.clk(clk), .reset(reset), .d(spi_di),  .q(di_s));

    // ncs_d clears to 0 so a frame already in progress across reset never looks like a start.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_d <= 1'b0;
            ncs_d <= 1'b0;
        end else begin
            sck_d <= sck_s;
            ncs_d <= ncs_s;
        end
    end

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign ncs_fall = ncs_d & ~ncs_s;
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sr_in    <= '0;
            sr_out   <= '0;
            hdr_addr <= '0;
            spi_do   <= 1'b0;
            r_valid  <= 1'b0;
            r_wen    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_valid <= 1'b0;
            if (r_valid && !r_wen)
                sr_out <= r_rdata;

            if (ncs_s) begin
                state  <= ST_IDLE;
                cnt    <= '0;
                spi_do <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ncs_fall) begin
                            state <= ST_HDR;
                            cnt   <= '0;
                        end
                    end
                    ST_HDR: begin
                        if (sck_rise) begin
                            sr_in <= {sr_in[DATA_W-2:0], di_s};
                            cnt   <= cnt_inc;
                            if (cnt == HDR_LAST) begin
                                hdr_addr <= {sr_in[ADDR_W-2:0], di_s};
                                if (sr_in[W_BIT-1]) begin
                                    state <= ST_WDATA;
                                end else begin
                                    state   <= ST_TURN;
                                    r_valid <= 1'b1;
                                    r_wen   <= 1'b0;
                                    r_addr  <= {sr_in[ADDR_W-2:0], di_s};
                                end
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sck_rise) begin
                            sr_in <= {sr_in[DATA_W-2:0], di_s};
                            cnt   <= cnt_inc;
                            if (cnt == WDATA_LAST) begin
                                state   <= ST_DONE;
                                r_valid <= 1'b1;
                                r_wen   <= 1'b1;
                                r_addr  <= hdr_addr;
                                r_wdata <= {sr_in[DATA_W-2:0], di_s};
                            end
                        end
                    end
                    ST_TURN: begin
                        spi_do <= 1'b0;
                        if (sck_rise) begin
                            cnt <= cnt_inc;
                            if (cnt == TURN_LAST)
                                state <= ST_RDATA;
                        end
                    end
                    ST_RDATA: begin
                        if (sck_fall) begin
                            spi_do <= sr_out[DATA_W-1];
                            sr_out <= {sr_out[DATA_W-2:0], 1'b0};
                        end
                        if (sck_rise) begin
                            cnt <= cnt_inc;
                            if (cnt == RDATA_LAST) begin
                                state  <= ST_DONE;
                                spi_do <= 1'b0;
                            end
                        end
                    end
                    ST_DONE: begin
                        spi_do <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_if.sv
// Directed SPI frames against spi_reg_if with a queue-based strobe scoreboard.
module tb_spi_reg_if;

    localparam int HALF = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_ncs = 1'b1;
    logic        spi_di = 1'b0;
    logic        spi_do;
    logic        r_valid;
    logic        r_wen;
    logic [11:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic [31:0] mem [0:4095];
    logic [63:0] mosi_sr;
    logic [63:0] miso_sr;

    typedef struct {
        logic        wen;
        logic [11:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    assign r_rdata = mem[r_addr];

    spi_reg_if #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .spi_clk (spi_clk),
        .spi_ncs (spi_ncs),
        .spi_di  (spi_di),
        .spi_do  (spi_do),
        .r_valid (r_valid),
        .r_wen   (r_wen),
        .r_addr  (r_addr),
        .r_wdata (r_wdata),
        .r_rdata (r_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected access.
    always @(negedge clk) begin
        if (!reset && r_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_strobe: got wen=%0b addr=0x%0h expected no strobe", r_wen, r_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_wen", 64'(r_wen), 64'(e.wen));
                check("strobe_addr", 64'(r_addr), 64'(e.addr));
                if (e.wen) begin
                    check("strobe_wdata", 64'(r_wdata), 64'(e.wdata));
                    mem[r_addr] = r_wdata;
                end
            end
        end
    end

    task automatic expect_access(input logic wen, input logic [11:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.wen   = wen;
        e.addr  = addr;
        e.wdata = wdata;
        exp_q.push_back(e);
    endtask

    task automatic spi_begin();
        spi_ncs = 1'b0;
        #HALF;
    endtask

    task automatic spi_bits(input int n);
        for (int i = 0; i < n; i++) begin
            spi_di  = mosi_sr[63];
            mosi_sr = {mosi_sr[62:0], 1'b0};
            #HALF;
            miso_sr = {miso_sr[62:0], spi_do};
            spi_clk = 1'b1;
            #HALF;
            spi_clk = 1'b0;
        end
    endtask

    task automatic spi_end();
        #HALF;
        spi_ncs = 1'b1;
        spi_di  = 1'b0;
        #(4 * HALF);
    endtask

    task automatic frame(input logic [15:0] hdr, input logic [31:0] data, input int nbits);
        mosi_sr = {hdr, data, 16'h0000};
        miso_sr = '0;
        spi_begin();
        spi_bits(nbits);
        spi_end();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[12'h040] = 32'h12345678;

        repeat (4) @(negedge clk);
        reset = 1'b0;
        check("reset_valid", 64'(r_valid), 64'h0);
        check("reset_wen", 64'(r_wen), 64'h0);
        check("reset_addr", 64'(r_addr), 64'h0);
        check("reset_wdata", 64'(r_wdata), 64'h0);
        check("reset_do", 64'(spi_do), 64'h0);
        repeat (4) @(negedge clk);

        // Plain write
        expect_access(1'b1, 12'h004, 32'hDEADBEEF);
        frame(16'h8004, 32'hDEADBEEF, 48);
        check("write_pending", 64'(exp_q.size()), 64'h0);
        check("write_hold_addr", 64'(r_addr), 64'h004);

        // Read: 16 header bits and 8 turnaround bits of zero, then data MSB first
        expect_access(1'b0, 12'h040, 32'h0);
        frame(16'h0040, 32'h0, 56);
        check("read_pending", 64'(exp_q.size()), 64'h0);
        check("read_miso", miso_sr[55:0], 64'h0000_0000_1234_5678);
        check("read_hold_wen", 64'(r_wen), 64'h0);
        check("read_hold_addr", 64'(r_addr), 64'h040);
        check("read_do_idle", 64'(spi_do), 64'h0);

        // Abort after 30 bits of a write, then a full write
        frame(16'h8123, 32'hFFFF0000, 30);
        check("abort_pending", 64'(exp_q.size()), 64'h0);
        check("abort_addr_held", 64'(r_addr), 64'h040);
        expect_access(1'b1, 12'h123, 32'hA5A55A5A);
        frame(16'h8123, 32'hA5A55A5A, 48);
        check("after_abort_pending", 64'(exp_q.size()), 64'h0);

        // Back-to-back write then read of the same register
        expect_access(1'b1, 12'h001, 32'h00000001);
        expect_access(1'b0, 12'h001, 32'h0);
        frame(16'h8001, 32'h00000001, 48);
        frame(16'h0001, 32'h0, 56);
        check("b2b_pending", 64'(exp_q.size()), 64'h0);
        check("b2b_miso", miso_sr[55:0], 64'h0000_0000_0000_0001);

        // Reset after 20 bits; the rest of that frame must be ignored
        mosi_sr = {16'h8777, 32'h87654321, 16'h0000};
        miso_sr = '0;
        spi_begin();
        spi_bits(20);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("midrst_valid", 64'(r_valid), 64'h0);
        check("midrst_wen", 64'(r_wen), 64'h0);
        check("midrst_addr", 64'(r_addr), 64'h0);
        check("midrst_wdata", 64'(r_wdata), 64'h0);
        check("midrst_do", 64'(spi_do), 64'h0);
        spi_bits(28);
        spi_end();
        check("midrst_pending", 64'(exp_q.size()), 64'h0);
        check("midrst_addr_after", 64'(r_addr), 64'h0);
        expect_access(1'b1, 12'h777, 32'h87654321);
        frame(16'h8777, 32'h87654321, 48);
        check("after_rst_pending", 64'(exp_q.size()), 64'h0);

        // 60 SCK pulses in a write frame
        expect_access(1'b1, 12'hABC, 32'hCAFEF00D);
        frame(16'h8ABC, 32'hCAFEF00D, 60);
        check("extra_pending", 64'(exp_q.size()), 64'h0);
        check("extra_hold_wdata", 64'(r_wdata), 64'hCAFEF00D);

        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
